dmem_master: RTL and testbench

Initiator side of the CPU's data-memory port: accepts one load/store request at a time from the pipeline over a valid/ready handshake and drives the async data memory's address, data, size, and read/write enables. Loads return with byte/halfword lane extraction and sign extension. Illegal or out-of-window accesses are rejected with an error response. Sits between the MEM stage and the data memory; the memory reads combinationally and commits writes on the rising clock edge.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_load_align.sv | 34 +++
 rtl/dmem_master.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory initiator.
//   - size encodings as carried on req_size / mem_size
//   - FSM state type
//   - window base and beat-counter width
//   - small helpers for alignment checks and store-data formatting
// Optional feature macro used by the importers: DMEM_UNALIGNED_EN.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_UNAL = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    // Required value of addr[31:16] for any access.
    localparam logic [15:0] MEM_ADDR = 16'h1000;

    // Enough to count the four byte beats of a split word access.
    localparam int BEAT_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

    // Store data is right-justified; unused upper bits are cleared.
    function automatic logic [31:0] store_format(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {24'b0, data[7:0]};
            SZ_HALF: return {16'b0, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load lane extraction and extension.
// Ports:
//   rdata      in  32  raw word from memory (little-endian lanes)
//   addr_lo    in   2  byte offset of the access within the word
//   size       in   2  SZ_BYTE / SZ_HALF / SZ_WORD
//   is_signed  in   1  sign-extend (1) or zero-extend (0)
//   load_data  out 32  extracted, extended result
// For split (byte-beat) accesses the top instantiates this in byte mode
// with is_signed = 0 and assembles the bytes itself.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [15:0] half_v;

    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{is_signed & half_v[15]}}, half_v};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_master.sv
// dmem_master: initiator side of the CPU data-memory port.
// Accepts one load/store at a time, drives the async memory for one beat
// (or several byte beats for split misaligned accesses) and returns a
// one-cycle response pulse.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester holds its fields until then.
// req_ready is high only in IDLE while reset is deasserted.
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata
//   rsp_valid/rsp_err/rsp_rdata   response pulse and payload
//   mem_addr/mem_wdata/mem_size/mem_we/mem_re/mem_rdata   memory side
//   dbg_state                      current FSM state
// Configuration: DMEM_UNALIGNED_EN splits misaligned half/word requests
// into byte beats; without it they take the FAULT path.
module dmem_master
    import dmem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output state_e      dbg_state
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [31:0] beat_addr;
    logic [31:0] beat_wdata;
    logic [1:0]  beat_size;
    logic        beat_bad;
    logic        last_beat;
    logic [1:0]  align_size;
    logic        align_signed;
    logic [31:0] align_data;
    logic [31:0] load_result;
    logic        req_illegal;

`ifdef DMEM_UNALIGNED_EN
    logic              split_q, split_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] beat_last;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       acc_full;
    logic [4:0]        beat_shift;
    logic [31:0]       wdata_sh;

    always_comb begin
        beat_addr  = addr_q + {{(32-BEAT_W){1'b0}}, beat_q};
        beat_shift = {beat_q, 3'b000};
        beat_last  = split_q ? ((size_q == SZ_HALF) ? BEAT_W'(1) : BEAT_W'(3)) : '0;
        last_beat  = (beat_q == beat_last);
        // Only split beats can walk out of the window; beat 0 was checked at accept.
        beat_bad   = (beat_addr[31:16] != MEM_ADDR);
        beat_size  = split_q ? SZ_BYTE : size_q;
        wdata_sh   = wdata_q >> beat_shift;
        beat_wdata = split_q ? {24'b0, wdata_sh[7:0]} : wdata_q;
        align_size   = split_q ? SZ_BYTE : size_q;
        align_signed = split_q ? 1'b0 : signed_q;
        acc_full   = acc_q | ({24'b0, align_data[7:0]} << beat_shift);
        if (!split_q) begin
            load_result = align_data;
        end else if (size_q == SZ_HALF) begin
            load_result = {{16{signed_q & acc_full[15]}}, acc_full[15:0]};
        end else begin
            load_result = acc_full;
        end
        req_illegal = (req_size == SZ_UNAL) || (req_addr[31:16] != MEM_ADDR);
    end
`else
    always_comb begin
        beat_addr    = addr_q;
        last_beat    = 1'b1;
        beat_bad     = 1'b0;
        beat_size    = size_q;
        beat_wdata   = wdata_q;
        align_size   = size_q;
        align_signed = signed_q;
        load_result  = align_data;
        req_illegal  = (req_size == SZ_UNAL) || (req_addr[31:16] != MEM_ADDR) ||
                       is_misaligned(req_size, req_addr[1:0]);
    end
`endif

    dmem_load_align u_load_align (
        .rdata     (mem_rdata),
        .addr_lo   (beat_addr[1:0]),
        .size      (align_size),
        .is_signed (align_signed),
        .load_data (align_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        we_d        = we_q;
        signed_d    = signed_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef DMEM_UNALIGNED_EN
        split_d     = split_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d   = req_addr;
                    wdata_d  = store_format(req_size, req_wdata);
                    size_d   = req_size;
                    we_d     = req_we;
                    signed_d = req_signed;
`ifdef DMEM_UNALIGNED_EN
                    split_d  = is_misaligned(req_size, req_addr[1:0]);
                    beat_d   = '0;
                    acc_d    = '0;
`endif
                    state_d  = req_illegal ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                if (beat_bad) begin
                    // Abort: earlier committed store beats stay in memory.
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (last_beat) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : load_result;
                end else begin
`ifdef DMEM_UNALIGNED_EN
                    beat_d = beat_q + BEAT_W'(1);
                    acc_d  = acc_full;
`endif
                end
            end
            FAULT: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SZ_BYTE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef DMEM_UNALIGNED_EN
            split_q     <= 1'b0;
            beat_q      <= '0;
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            we_q        <= we_d;
            signed_q    <= signed_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_UNALIGNED_EN
            split_q     <= split_d;
            beat_q      <= beat_d;
            acc_q       <= acc_d;
`endif
        end
    end

    // Strobes decode the state register directly so they drop the moment
    // reset forces the state back to IDLE.
    assign req_ready = (state_q == IDLE) && reset;
    assign mem_we    = (state_q == ACCESS) && we_q && !beat_bad;
    assign mem_re    = (state_q == ACCESS) && !we_q && !beat_bad;
    assign mem_addr  = beat_addr;
    assign mem_wdata = beat_wdata;
    assign mem_size  = beat_size;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: table of directed vectors, randomized requests
// checked against a byte-array reference model, and a reset-abort sequence.
module tb_dmem_master;
  import dmem_pkg::*;

`ifdef DMEM_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_we, mem_re;
  state_e      dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  dmem_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- memory fixture ----------------
  // Two 256-byte pages: 0x1000_00xx and 0x1000_FFxx.
  logic [7:0] seed_mem [512];
  logic [7:0] fmem [512];
  logic [7:0] rmem [512];
  logic       mem_load;

  function automatic int fidx(input logic [31:0] a);
    return int'({a[15], a[7:0]});
  endfunction

  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 512; i++) fmem[i] <= seed_mem[i];
    end else if (mem_we) begin
      fmem[fidx(mem_addr)] <= mem_wdata[7:0];
      if (mem_size != 2'd0) fmem[fidx(mem_addr + 32'd1)] <= mem_wdata[15:8];
      if (mem_size == 2'd3) begin
        fmem[fidx(mem_addr + 32'd2)] <= mem_wdata[23:16];
        fmem[fidx(mem_addr + 32'd3)] <= mem_wdata[31:24];
      end
    end
  end

  logic [31:0] rd_base;
  always_comb begin
    rd_base   = {mem_addr[31:2], 2'b00};
    mem_rdata = {fmem[fidx(rd_base + 32'd3)], fmem[fidx(rd_base + 32'd2)],
                 fmem[fidx(rd_base + 32'd1)], fmem[fidx(rd_base)]};
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Request-level: byte k of an access is address A+k; every byte must be
  // inside the window; bytes are assembled little-endian then extended.
  task automatic model_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e_err, output logic [31:0] e_rd,
                           output int e_lat, output logic e_strobe);
    int n;
    logic aligned;
    logic [31:0] full, ext, ak;
    aligned  = (sz == 2'd0) || (sz == 2'd1 && !a[0]) || (sz == 2'd3 && a[1:0] == 2'b00);
    n        = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e_err    = 1'b0;
    e_rd     = 32'h0;
    e_lat    = 1;
    e_strobe = 1'b1;
    if (sz == 2'd2 || a[31:16] != 16'h1000 || (!UNAL && !aligned)) begin
      e_err    = 1'b1;
      e_strobe = 1'b0;
      return;
    end
    full = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      if (ak[31:16] != 16'h1000) begin
        e_err = 1'b1;
        e_lat = k + 1;
        return;
      end
      if (we) rmem[fidx(ak)] = wd[8*k +: 8];
      else    full[8*k +: 8] = rmem[fidx(ak)];
    end
    e_lat = aligned ? 1 : n;
    case (sz)
      2'd0:    ext = {{24{sg & full[7]}}, full[7:0]};
      2'd1:    ext = {{16{sg & full[15]}}, full[15:0]};
      default: ext = full;
    endcase
    e_rd = we ? 32'h0 : ext;
  endtask

  // ---------------- driver ----------------
  // Entered #1 after a rising edge; returns #1 after the response edge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic got_err, output logic [31:0] got_rd, output int lat,
                        output logic saw_we, output logic saw_re, output logic rdy_ok,
                        output logic timed_out);
    int n;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0; timed_out = 1'b0; lat = 0; saw_we = 1'b0; saw_re = 1'b0; rdy_ok = 1'b1;
    got_err = 1'b0; got_rd = 32'h0;
    while (!req_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    if (!req_ready) begin
      timed_out = 1'b1;
      req_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
    forever begin
      saw_we |= mem_we;
      saw_re |= mem_re;
      if (rsp_valid) begin
        if (!req_ready) rdy_ok = 1'b0;
        break;
      end
      if (req_ready) rdy_ok = 1'b0;
      if (lat >= 10) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clock); #1; lat++;
    end
    got_err = rsp_err;
    got_rd  = rsp_rdata;
  endtask

  task automatic run_and_check(input string tag, input logic we, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd,
                               input logic x_err, input logic [31:0] x_rd, input int x_lat,
                               input logic x_strobe);
    logic g_err, s_we, s_re, r_ok, t_o;
    logic [31:0] g_rd;
    int g_lat;
    do_req(we, sz, sg, a, wd, g_err, g_rd, g_lat, s_we, s_re, r_ok, t_o);
    chk({tag, ".timeout"}, 32'(t_o), 32'd0);
    if (!t_o) begin
      chk({tag, ".err"}, 32'(g_err), 32'(x_err));
      chk({tag, ".rdata"}, g_rd, x_rd);
      chk({tag, ".latency"}, 32'(g_lat), 32'(x_lat));
      chk({tag, ".strobes"}, {30'b0, s_we, s_re}, {30'b0, x_strobe & we, x_strobe & !we});
      chk({tag, ".ready"}, 32'(r_ok), 32'd1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic m_err, m_strobe;
    logic [31:0] m_rd, ra, rwd;
    logic [1:0] rsz;
    int m_lat, r;

    reset = 1'b0; mem_load = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 512; i++) begin
      seed_mem[i] = 8'($urandom);
      rmem[i]     = seed_mem[i];
    end

    // Reset state.
    #1;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_err",   32'(rsp_err),   32'd0);
    chk("rst.rsp_rdata", rsp_rdata,      32'd0);
    chk("rst.mem_addr",  mem_addr,       32'd0);
    chk("rst.mem_wdata", mem_wdata,      32'd0);
    chk("rst.mem_size",  32'(mem_size),  32'd0);
    chk("rst.mem_we_re", {30'b0, mem_we, mem_re}, 32'd0);
    chk("rst.ready_low", 32'(req_ready), 32'd0);
    chk("rst.state",     32'(dbg_state), 32'(IDLE));
    repeat (3) @(posedge clock);
    #1; mem_load = 1'b0;
    #3; reset = 1'b1;
    @(posedge clock); #1;
    chk("rst.ready_high", 32'(req_ready), 32'd1);

    // Directed table.
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h1000_0004, 32'h8070_6050, 1'b0, 32'h0, 1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h1000_0004, 32'h0, 1'b0, 32'h8070_6050, 1});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h1000_0007, 32'h0, 1'b0, 32'hFFFF_FF80, 1});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h1000_0007, 32'h0, 1'b0, 32'h0000_0080, 1});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h1000_0006, 32'h1234_BEEF, 1'b0, 32'h0, 1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h1000_0004, 32'h0, 1'b0, 32'hBEEF_6050, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h1000_0006, 32'h0, 1'b0, 32'hFFFF_BEEF, 1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h1000_0004, 32'h0, 1'b0, 32'h0000_6050, 1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 1'b1, 32'h0, 1});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0, 1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h2000_0000, 32'h0, 1'b1, 32'h0, 1});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h2000_0000, 32'h1111_1111, 1'b1, 32'h0, 1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h1000_0005, 32'hFFFF_FFAB, 1'b0, 32'h0, 1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h1000_0004, 32'h0, 1'b0, 32'hBEEF_AB50, 1});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 32'h1000_0004, 32'h8070_6050, 1'b0, 32'h0, 1});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h1000_0008, 32'h0000_0011, 1'b0, 32'h0, 1});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h1000_0005, 32'h0, !UNAL,
                    UNAL ? 32'h1180_7060 : 32'h0, UNAL ? 4 : 1});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h1000_0007, 32'h0, !UNAL,
                    UNAL ? 32'h0000_1180 : 32'h0, UNAL ? 2 : 1});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h1000_0009, 32'h0000_CAFE, !UNAL, 32'h0, UNAL ? 2 : 1});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h1000_0009, 32'h0, !UNAL,
                    UNAL ? 32'h0000_CAFE : 32'h0, UNAL ? 2 : 1});

    foreach (tbl[i]) begin
      model_req(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, m_err, m_rd, m_lat, m_strobe);
      run_and_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
                    tbl[i].err, tbl[i].rd, tbl[i].lat, !tbl[i].err);
    end

    // Randomized requests against the reference model.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      ra = 32'h1000_0000 + 32'($urandom_range(0, 250));
      else if (r < 9) ra = 32'h1000_FFF8 + 32'($urandom_range(0, 7));
      else            ra = 32'h2000_0000 | 32'($urandom_range(0, 255));
      r = $urandom_range(0, 15);
      rsz = (r == 0) ? 2'd2 : (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : 2'd3;
      rwd = $urandom;
      req_we = 1'($urandom);
      req_signed = 1'($urandom);
      model_req(req_we, rsz, req_signed, ra, rwd, m_err, m_rd, m_lat, m_strobe);
      run_and_check($sformatf("rnd%0d", t), req_we, rsz, req_signed, ra, rwd,
                    m_err, m_rd, m_lat, m_strobe);
    end

    // Reset asserted in the middle of a store: strobes drop at once,
    // no response, ready again once reset is released.
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_wdata = 32'hA1B2_C3D4;
    req_addr  = UNAL ? 32'h1000_0011 : 32'h1000_0010;
    chk("abort.ready_before", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("abort.we_beat0", 32'(mem_we), 32'd1);
`ifdef DMEM_UNALIGNED_EN
    @(posedge clock); #1;
    chk("abort.we_beat1", 32'(mem_we), 32'd1);
    chk("abort.addr_beat1", mem_addr, 32'h1000_0012);
    rmem[fidx(32'h1000_0011)] = 8'hD4;
`endif
    #2; reset = 1'b0;
    #1;
    chk("abort.we_drop", {30'b0, mem_we, mem_re}, 32'd0);
    chk("abort.ready_in_reset", 32'(req_ready), 32'd0);
    chk("abort.state", 32'(dbg_state), 32'(IDLE));
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      chk($sformatf("abort.no_rsp%0d", c), 32'(rsp_valid), 32'd0);
    end
    #2; reset = 1'b1;
    @(posedge clock); #1;
    chk("abort.ready_after", 32'(req_ready), 32'd1);
    chk("abort.no_rsp_after", 32'(rsp_valid), 32'd0);
    model_req(1'b0, SZ_WORD, 1'b0, 32'h1000_0010, 32'h0, m_err, m_rd, m_lat, m_strobe);
    run_and_check("abort.readback", 1'b0, SZ_WORD, 1'b0, 32'h1000_0010, 32'h0,
                  m_err, m_rd, m_lat, m_strobe);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
